wr_capture_buffer: RTL and testbench
====================================

// Module: wr_capture_buffer
// PURPOSE
//  Receiving end of the accelerator write interface: captures every wr_req/wr_data beat produced by
//  accelerator_wrappers into an internal buffer between start and done, then serves the stored words
//  back in order through a simple read-request port. It sits beside the accelerator in top-level
//  benches and in the system, replacing a free-running write sink.
// PARAMETERS
//  DATA_W   21  width of wr_data / rd_data
//  DEPTH    32  buffer capacity in words (power of two)
//  ADDR_W   5   log2(DEPTH); count width is ADDR_W+1
// PORTS
//  clk           in   1         system clock; all state on rising edge
//  rst           in   1         asynchronous, active-low reset
//  start         in   1         arm capture; same start pulse that launches the accelerator
//  wr_req        in   1         write beat valid (one word per cycle high, no backpressure)
//  wr_data       in   DATA_W    write beat payload
//  done          in   1         accelerator finished (level or pulse; first high cycle counts)
//  rd_req        in   1         request next stored word (honoured only in COMPLETE)
//  rd_valid      out  1         rd_data valid, exactly 1 cycle after an honoured rd_req
//  rd_data       out  DATA_W    word read out, held until next honoured rd_req
//  rd_empty      out  1         COMPLETE and all captured words already read
//  word_count    out  ADDR_W+1  words stored this capture (0..DEPTH)
//  overflow      out  1         sticky: a beat arrived while buffer full
//  capture_done  out  1         high while in COMPLETE
// BEHAVIOUR
//  - Reset (rst low, async): state IDLE; wr_ptr, rd_ptr, word_count=0; rd_valid, rd_data, overflow,
//    capture_done, rd_empty = 0. Buffer contents not cleared.
//  - FSM IDLE -> CAPTURE on start. CAPTURE -> COMPLETE on done. COMPLETE stays until start.
//    start in any state (incl. mid-CAPTURE): next state CAPTURE, pointers/count/overflow cleared,
//    rd_valid dropped; start dominates done and rd_req in the same cycle.
//  - CAPTURE: wr_req with word_count<DEPTH writes wr_data at wr_ptr, wr_ptr++, word_count++ (visible
//    next cycle). wr_req with word_count==DEPTH: data dropped, overflow set, count unchanged.
//  - wr_req and done in the same cycle: the beat is stored, then COMPLETE. wr_req in IDLE/COMPLETE ignored.
//  - start and wr_req same cycle: beat ignored (capture begins the cycle after start).
//  - COMPLETE: rd_req with rd_ptr<word_count -> rd_data<=mem[rd_ptr], rd_valid=1 next cycle, rd_ptr++.
//    rd_req with rd_ptr==word_count -> ignored, rd_valid=0. rd_empty = COMPLETE && rd_ptr==word_count.
//  - rd_valid is a 1-cycle pulse per honoured rd_req; back-to-back rd_req gives one word per cycle.
//  - DEPTH beats exactly: word_count=DEPTH, overflow stays 0; wr_ptr wraps to 0 but is not reused.
//  - Zero-length capture (done before any beat): COMPLETE with word_count=0, rd_empty=1 immediately.
// CONFIGURATION
//  WR_CAPTURE_CHECKSUM_EN defined: extra port checksum out DATA_W = XOR of all stored words this
//    capture; cleared on reset and start; updated in the same cycle a word is written (dropped
//    overflow beats excluded); frozen in COMPLETE.
//  Not defined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  - Shared package wr_capture_pkg: state enum (IDLE, CAPTURE, COMPLETE) as 2-bit localparams,
//    default DATA_W/DEPTH constants shared with accelerator_wrappers.
//  - One sub-module: wr_capture_ram (DEPTH x DATA_W, 1 synchronous write port, 1 synchronous read
//    port, no reset). Control FSM, pointers and flags stay in wr_capture_buffer.
// TESTING
//  1 Reset: rst low 30 ns mid-activity -> all outputs 0, state IDLE; rd_req in IDLE -> no rd_valid.
//  2 start, 4 beats 21'h00001..21'h00004, done -> word_count=4, capture_done=1; 5 rd_req
//    -> rd_data 1,2,3,4 with rd_valid, 5th ignored, rd_empty=1.
//  3 DEPTH+3 beats (35 for DEPTH=32) -> word_count=32, overflow=1; readout returns first 32 words.
//  4 Last beat 21'h1FFFFF coincident with done -> stored, word_count includes it, readout ends with 1FFFFF.
//  5 start after 2 beats, then 3 beats A,B,C, done -> word_count=3, overflow=0, readout A,B,C only.
//  6 WR_CAPTURE_CHECKSUM_EN: beats 21'h0F0F0, 21'h00FFF -> checksum=21'h0FF0F; start -> checksum=0.

Source files
------------

// File: rtl/wr_capture_pkg.sv
// Shared types and default sizing for the accelerator write-capture path.
// Imported by wr_capture_buffer and wr_capture_ram.
package wr_capture_pkg;

   localparam int WR_DATA_W = 21;
   localparam int WR_DEPTH  = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURE  = 2'd1,
      COMPLETE = 2'd2
   } state_t;

endpackage

// File: rtl/wr_capture_ram.sv
// Capture storage: one synchronous write port, one synchronous read port.
// No reset; the read register holds until the next read enable.
module wr_capture_ram
   import wr_capture_pkg::*;
#(
   parameter int DATA_W = WR_DATA_W,
   parameter int DEPTH  = WR_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/wr_capture_buffer.sv
// Captures accelerator write beats between start and done, then replays them in order.
// Optional WR_CAPTURE_CHECKSUM_EN adds an XOR checksum of the stored words.
module wr_capture_buffer
   import wr_capture_pkg::*;
#(
   parameter int DATA_W = WR_DATA_W,
   parameter int DEPTH  = WR_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              wr_req,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              done,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_empty,
   output logic [ADDR_W:0]   word_count,
   output logic              overflow,
`ifdef WR_CAPTURE_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   output logic              capture_done
);

   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic              wr_en, rd_en, ovf_set;
   logic              rd_seen;
   logic [DATA_W-1:0] ram_q;
   logic              full, drained;

   assign full    = (word_count == FULL);
   assign drained = (rd_ptr == word_count);

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      ovf_set  = 1'b0;
      if (start) begin
         state_nx = CAPTURE;
      end else begin
         unique case (state)
            CAPTURE: begin
               wr_en   = wr_req && !full;
               ovf_set = wr_req && full;
               if (done)
                  state_nx = COMPLETE;
            end
            COMPLETE: rd_en = rd_req && !drained;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         word_count <= '0;
         overflow   <= 1'b0;
         rd_valid   <= 1'b0;
         rd_seen    <= 1'b0;
      end else begin
         state    <= state_nx;
         rd_valid <= rd_en;
         if (start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
         end else begin
            if (wr_en) begin
               wr_ptr     <= wr_ptr + 1'b1;
               word_count <= word_count + 1'b1;
            end
            if (ovf_set)
               overflow <= 1'b1;
            if (rd_en) begin
               rd_ptr  <= rd_ptr + 1'b1;
               rd_seen <= 1'b1;
            end
         end
      end
   end

`ifdef WR_CAPTURE_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         checksum <= '0;
      else if (start)
         checksum <= '0;
      else if (wr_en)
         checksum <= checksum ^ wr_data;
   end
`endif

   wr_capture_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .re    (rd_en),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (ram_q)
   );

   // RAM has no reset; mask its output until a word has actually been read.
   assign rd_data      = rd_seen ? ram_q : '0;
   assign capture_done = (state == COMPLETE);
   assign rd_empty     = capture_done && drained;

endmodule

// File: tb/tb_wr_capture_buffer.sv
// Self-checking bench for wr_capture_buffer against a queue-based capture model.
// Build with +define+WR_CAPTURE_CHECKSUM_EN to cover the checksum port.
module tb_wr_capture_buffer;

   localparam int DW    = 21;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          wr_req = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          done = 1'b0;
   logic          rd_req = 1'b0;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_empty;
   logic [AW:0]   word_count;
   logic          overflow;
   logic          capture_done;
`ifdef WR_CAPTURE_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   wr_capture_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .wr_req       (wr_req),
      .wr_data      (wr_data),
      .done         (done),
      .rd_req       (rd_req),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_empty     (rd_empty),
      .word_count   (word_count),
      .overflow     (overflow),
`ifdef WR_CAPTURE_CHECKSUM_EN
      .checksum     (checksum),
`endif
      .capture_done (capture_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model: 0 idle, 1 capturing, 2 complete
   int            m_mode;
   logic [DW-1:0] m_q[$];
   int            m_ridx;
   logic          m_ovf;
   logic          m_valid;
   logic [DW-1:0] m_last;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_xor();
      logic [DW-1:0] x = '0;
      foreach (m_q[i]) x ^= m_q[i];
      return x;
   endfunction

   task automatic m_reset();
      m_mode  = 0;
      m_q.delete();
      m_ridx  = 0;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
      m_last  = '0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":rd_valid"}, 32'(rd_valid), 32'(m_valid));
      chk({tag, ":rd_data"}, 32'(rd_data), 32'(m_last));
      chk({tag, ":word_count"}, 32'(word_count), 32'(m_q.size()));
      chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ":capture_done"}, 32'(capture_done), 32'(m_mode == 2));
      chk({tag, ":rd_empty"}, 32'(rd_empty),
          32'(m_mode == 2 && m_ridx == m_q.size()));
`ifdef WR_CAPTURE_CHECKSUM_EN
      chk({tag, ":checksum"}, 32'(checksum), 32'(m_xor()));
`endif
   endtask

   // One clock: drive inputs, advance the model by the spec rules, check.
   task automatic cyc(input string tag, input logic st, input logic wr,
                      input logic [DW-1:0] d, input logic dn, input logic rr);
      start = st; wr_req = wr; wr_data = d; done = dn; rd_req = rr;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      if (st) begin
         m_mode = 1;
         m_q.delete();
         m_ridx = 0;
         m_ovf  = 1'b0;
      end else if (m_mode == 1) begin
         if (wr) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
         end
         if (dn) m_mode = 2;
      end else if (m_mode == 2) begin
         if (rr && m_ridx < m_q.size()) begin
            m_last  = m_q[m_ridx];
            m_ridx++;
            m_valid = 1'b1;
         end
      end
      start = 0; wr_req = 0; done = 0; rd_req = 0;
      check_all(tag);
   endtask

   task automatic read_out(input string tag, input int n, input bit gaps);
      for (int i = 0; i < n; i++)
         cyc(tag, 0, 0, '0, 0, gaps ? 1'($urandom_range(0, 1)) : 1'b1);
      cyc(tag, 0, 0, '0, 0, 0);
   endtask

   initial begin
      m_reset();
      #23 rst = 1'b1;
      #2;
      check_all("post_reset");

      // mid-activity reset
      cyc("t1", 1, 0, '0, 0, 0);
      cyc("t1", 0, 1, 21'h12345, 0, 0);
      #2 rst = 1'b0;
      m_reset();
      #30;
      check_all("t1_in_reset");
      #2 rst = 1'b1;
      cyc("t1_idle_rd", 0, 0, '0, 0, 1);
      cyc("t1_idle_rd", 0, 1, 21'h7, 0, 1);

      // four beats then five reads
      cyc("t2", 1, 0, '0, 0, 0);
      for (int i = 1; i <= 4; i++) cyc("t2", 0, 1, DW'(i), 0, 0);
      cyc("t2", 0, 0, '0, 1, 0);
      chk("t2_count4", 32'(word_count), 32'd4);
      read_out("t2_rd", 5, 0);
      chk("t2_last", 32'(rd_data), 32'd4);
      chk("t2_empty", 32'(rd_empty), 32'd1);

      // overflow: DEPTH+3 beats
      cyc("t3", 1, 0, '0, 0, 0);
      for (int i = 0; i < DEPTH + 3; i++)
         cyc("t3", 0, 1, DW'($urandom), 0, 0);
      cyc("t3", 0, 0, '0, 1, 0);
      chk("t3_full", 32'(word_count), 32'(DEPTH));
      chk("t3_ovf", 32'(overflow), 32'd1);
      read_out("t3_rd", DEPTH + 2, 0);

      // exactly DEPTH beats, last one with done
      cyc("t4", 1, 0, '0, 0, 0);
      for (int i = 0; i < DEPTH - 1; i++)
         cyc("t4", 0, 1, DW'($urandom), 0, 0);
      cyc("t4", 0, 1, 21'h1FFFFF, 1, 0);
      chk("t4_count", 32'(word_count), 32'(DEPTH));
      chk("t4_noovf", 32'(overflow), 32'd0);
      read_out("t4_rd", DEPTH, 0);
      chk("t4_tail", 32'(rd_data), 32'h1FFFFF);

      // restart mid-capture; start+wr_req beat ignored
      cyc("t5", 1, 0, '0, 0, 0);
      cyc("t5", 0, 1, 21'h0DEAD, 0, 0);
      cyc("t5", 0, 1, 21'h0BEEF, 0, 0);
      cyc("t5", 1, 1, 21'h1CAFE, 0, 0);
      cyc("t5", 0, 1, 21'h0000A, 0, 0);
      cyc("t5", 0, 1, 21'h0000B, 0, 0);
      cyc("t5", 0, 1, 21'h0000C, 0, 0);
      cyc("t5", 0, 0, '0, 1, 0);
      chk("t5_count3", 32'(word_count), 32'd3);
      read_out("t5_rd", 4, 0);

      // zero-length capture, then start overriding rd_req in COMPLETE
      cyc("t7", 1, 0, '0, 0, 0);
      cyc("t7", 0, 0, '0, 1, 0);
      chk("t7_empty", 32'(rd_empty), 32'd1);
      cyc("t7", 0, 0, '0, 0, 1);
      cyc("t7", 1, 0, '0, 1, 1);
      cyc("t7", 0, 1, 21'h00055, 0, 0);
      cyc("t7", 0, 0, '0, 1, 0);
      cyc("t7", 1, 0, '0, 0, 1);
      chk("t7_start_dom", 32'(rd_valid), 32'd0);

`ifdef WR_CAPTURE_CHECKSUM_EN
      cyc("t6", 1, 0, '0, 0, 0);
      cyc("t6", 0, 1, 21'h0F0F0, 0, 0);
      cyc("t6", 0, 1, 21'h00FFF, 0, 0);
      cyc("t6", 0, 0, '0, 1, 0);
      chk("t6_csum", 32'(checksum), 32'h0FF0F);
      cyc("t6", 0, 1, 21'h11111, 0, 0);
      chk("t6_frozen", 32'(checksum), 32'h0FF0F);
      cyc("t6", 1, 0, '0, 0, 0);
      chk("t6_clear", 32'(checksum), 32'd0);
`endif

      // randomized captures with random gaps and random reads
      for (int r = 0; r < 12; r++) begin
         int n = $urandom_range(0, 45);
         cyc("rnd", 1, 0, '0, 0, 0);
         for (int i = 0; i < n; i++)
            cyc("rnd", 0, 1'($urandom_range(0, 1)), DW'($urandom),
                (i == n - 1) && 1'($urandom_range(0, 1)), 0);
         if (m_mode != 2) cyc("rnd", 0, 0, '0, 1, 0);
         read_out("rnd_rd", 2 * m_q.size() + 3, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
